// File: rtl/byte_word_packer.sv
// Byte-to-word packer: assembles a byte stream little-endian into 32-bit words,
// with a level-sensitive flush that emits a partial word plus byte enables.
module byte_word_packer #(
    parameter logic [7:0] FLUSH_FILL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_be,
    output logic [2:0]  out_count
);

    logic [31:0] r_acc;
    logic [1:0]  r_lane;
    logic [3:0]  r_be_acc;
    logic        r_out_valid;
    logic [31:0] r_out_word;
    logic [3:0]  r_out_be;
    logic [2:0]  r_out_count;

    logic        w_slot_free;
    logic        w_in_xfer;
    logic        w_complete;
    logic        w_flush_fire;
    logic        w_load;
    logic [3:0]  w_hit;
    logic [31:0] w_merged_acc;
    logic [3:0]  w_merged_be;
    logic [31:0] w_load_word;
    logic [2:0]  w_load_count;

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = (r_lane != 2'd3) || w_slot_free;
    assign w_in_xfer   = in_valid && in_ready;
    assign w_complete  = w_in_xfer && (r_lane == 2'd3);

    // The byte accepted this cycle is merged in before deciding what to emit,
    // so a same-cycle flush carries it and a completion sees all four lanes.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_hit[k]              = w_in_xfer && (r_lane == 2'(k));
        assign w_merged_be[k]        = r_be_acc[k] | w_hit[k];
        assign w_merged_acc[8*k +: 8] = w_hit[k] ? in_byte : r_acc[8*k +: 8];
        assign w_load_word[8*k +: 8]  = w_merged_be[k] ? w_merged_acc[8*k +: 8] : FLUSH_FILL;
    end

    always_comb begin
        w_load_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            w_load_count = w_load_count + {2'b00, w_merged_be[i]};
        end
    end

    assign w_flush_fire = flush && w_slot_free && (w_merged_be != 4'b0000) && !w_complete;
    assign w_load       = w_complete || w_flush_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= 32'h0;
            r_lane      <= 2'd0;
            r_be_acc    <= 4'b0000;
            r_out_valid <= 1'b0;
            r_out_word  <= 32'h0;
            r_out_be    <= 4'b0000;
            r_out_count <= 3'd0;
        end else begin
            if (w_load) begin
                r_acc    <= 32'h0;
                r_be_acc <= 4'b0000;
                r_lane   <= 2'd0;
            end else if (w_in_xfer) begin
                r_acc    <= w_merged_acc;
                r_be_acc <= w_merged_be;
                r_lane   <= r_lane + 2'd1;
            end

            // A load only happens when the slot is free, so it may overwrite
            // a word that is leaving this same cycle.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_word  <= w_load_word;
                r_out_be    <= w_merged_be;
                r_out_count <= w_load_count;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_be    = r_out_be;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = 8'h00;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [3:0]  out_be;
    logic [2:0]  out_count;

    int errs = 0;
    int checks = 0;

    byte_word_packer #(.FLUSH_FILL(8'h00)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_be(out_be),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes buffered so far plus the output register contents.
    logic [7:0]  m_buf[$];
    logic        m_ov = 1'b0;
    logic [31:0] m_word = 32'h0;
    logic [3:0]  m_be = 4'h0;
    logic [2:0]  m_cnt = 3'd0;

    // Inputs only change just after posedge, so at negedge they are exactly
    // what the next posedge will sample.
    initial forever begin
        logic        slot, rdy, acc_b;
        logic [7:0]  nb[$];
        @(negedge clk);
        slot = !m_ov || out_ready;
        rdy  = (m_buf.size() != 3) || slot;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        if (m_ov) begin
            chk("out_word", out_word, m_word);
            chk("out_be", {28'b0, out_be}, {28'b0, m_be});
            chk("out_count", {29'b0, out_count}, {29'b0, m_cnt});
        end
        if (rst) begin
            m_buf.delete();
            m_ov = 0; m_word = 0; m_be = 0; m_cnt = 0;
        end else begin
            acc_b = in_valid && rdy;
            nb = m_buf;
            if (acc_b) nb.push_back(in_byte);
            if (nb.size() == 4 || (flush && slot && nb.size() > 0)) begin
                m_ov = 1;
                m_word = 32'h0;
                for (int k = 0; k < nb.size(); k++) m_word[8*k +: 8] = nb[k];
                m_be  = 4'((1 << nb.size()) - 1);
                m_cnt = 3'(nb.size());
                m_buf.delete();
            end else begin
                m_buf = nb;
                if (m_ov && out_ready) m_ov = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit done = 0;
        in_valid = 1;
        in_byte  = b;
        for (int t = 0; t < 20 && !done; t++) begin
            if (in_ready) done = 1;
            tick();
        end
        if (!done) begin
            errs++; checks++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end
        in_valid = 0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_word", out_word, 32'h0);
        chk("rst_be", {28'b0, out_be}, 32'd0);
        chk("rst_count", {29'b0, out_count}, 32'd0);
        rst = 0;

        // Full word, back-to-back
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_word", out_word, 32'h44332211);
        chk("t1_be", {28'b0, out_be}, 32'hf);
        chk("t1_count", {29'b0, out_count}, 32'd4);
        tick();
        chk("t1_one_cycle", {31'b0, out_valid}, 32'd0);

        // Backpressure
        out_ready = 0;
        for (int i = 1; i <= 7; i++) send(8'(i));
        in_valid = 1; in_byte = 8'h08;
        chk("t2_stall_rdy", {31'b0, in_ready}, 32'd0);
        chk("t2_hold_word", out_word, 32'h04030201);
        tick();
        chk("t2_stall_rdy2", {31'b0, in_ready}, 32'd0);
        chk("t2_hold_word2", out_word, 32'h04030201);
        out_ready = 1; #1;
        chk("t2_rdy_release", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 0;
        chk("t2_b2b_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_b2b_word", out_word, 32'h08070605);
        tick();

        // Flush of a partial word
        send(8'hAA); send(8'hBB);
        flush = 1; tick(); flush = 0;
        chk("t3_word", out_word, 32'h0000BBAA);
        chk("t3_be", {28'b0, out_be}, 32'h3);
        chk("t3_count", {29'b0, out_count}, 32'd2);
        tick();

        // Flush with a same-cycle byte
        send(8'hAA); send(8'hBB);
        in_valid = 1; in_byte = 8'hCC; flush = 1;
        tick();
        in_valid = 0; flush = 0;
        chk("t4_word", out_word, 32'h00CCBBAA);
        chk("t4_be", {28'b0, out_be}, 32'h7);
        chk("t4_count", {29'b0, out_count}, 32'd3);
        tick();

        // Empty flush, then deferred flush
        flush = 1; tick(); flush = 0;
        chk("t5_empty_flush", {31'b0, out_valid}, 32'd0);
        out_ready = 0;
        send(8'h10); send(8'h11); send(8'h12); send(8'h13);
        send(8'hEE);
        flush = 1; tick(); tick();
        chk("t5_deferred_hold", out_word, 32'h13121110);
        out_ready = 1; tick(); flush = 0;
        chk("t5_deferred_valid", {31'b0, out_valid}, 32'd1);
        chk("t5_deferred_word", out_word, 32'h000000EE);
        chk("t5_deferred_be", {28'b0, out_be}, 32'h1);
        tick();

        // Reset discards buffered bytes
        send(8'h5A); send(8'h5B);
        rst = 1; tick();
        chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        rst = 0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("t6_word", out_word, 32'h04030201);
        chk("t6_be", {28'b0, out_be}, 32'hf);
        tick();

        // Random traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_byte   = 8'($urandom);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        in_valid = 0; flush = 0; rst = 0; out_ready = 1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Byte-to-word assembler: inverse of the byte-lane select path. Accepts a stream of 8-bit bytes and packs them little-endian into 32-bit words.
- Byte k of a word lands in bits [8k+7:8k], so a downstream lane select of k returns that byte.
- Used in front of word-wide memory/IO writes (e.g. a byte-serial loader filling instruction/data memory).
- A flush request emits a partial word with byte enables.

Parameters:
- FLUSH_FILL, 8'h00, value driven into unwritten lanes of a flushed partial word.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_byte is valid
- in_ready  output  1  packer can accept a byte this cycle (combinational)
- in_byte  input  8  data byte
- flush  input  1  level request to emit the buffered partial word
- out_valid  output  1  out_word/out_be/out_count valid
- out_ready  input  1  consumer accepts the output word
- out_word  output  32  packed word
- out_be  output  4  byte enables; bit k set means lane k was written
- out_count  output  3  number of valid bytes, 1..4

Behaviour:
- State:
  - accumulator acc[31:0]
  - lane pointer lane[1:0]
  - lane mask be_acc[3:0]
  - one output register holding out_word, out_be, out_count and out_valid.
- Reset (sync, rst=1 at clk edge) overrides all other inputs that cycle:
  - acc=0, lane=0, be_acc=0
  - out_valid=0, out_word=0, out_be=0, out_count=0
  - any buffered partial word is discarded.
- slot_free = !out_valid || out_ready.
- Handshakes:
  - in_ready = (lane != 3) || slot_free.
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Byte accept (no completion):
  - acc[8*lane+7:8*lane] <= in_byte
  - be_acc[lane] <= 1
  - lane <= lane+1.
- Word completion (byte accepted at lane 3):
  - output register loads {in_byte, acc[23:0]}, be 4'b1111, count 4
  - out_valid <= 1
  - acc <= 0, be_acc <= 0, lane <= 0 (wrap).
- Latency: out_valid is asserted the cycle after the edge that accepted the 4th byte.
- Flush fires when flush=1 && slot_free && (be_acc != 0 or a byte is accepted this cycle) and no completion occurs this cycle:
  - A byte accepted in the same cycle is included in the flushed word.
  - out_word = merged bytes; unwritten lanes are FLUSH_FILL.
  - out_be = merged mask; out_count = popcount(out_be).
  - out_valid <= 1; acc, be_acc and lane cleared.
- Flush is level-sensitive:
  - If slot_free=0, the flush is deferred until a cycle where slot_free=1, with flush still high.
  - Input acceptance continues normally while deferred.
- Flush coinciding with a completion: the completion takes priority. The full word is emitted and nothing remains to flush.
- Flush with empty accumulator and no byte accepted: no-op, out_valid unchanged.
- Output hold: while out_valid && !out_ready, out_word/out_be/out_count are stable.
- Output drain:
  - Output transfer with no new word loaded: out_valid <= 0.
  - Output transfer with a simultaneous load: back-to-back, out_valid stays 1 with the new word.
- Backpressure: with the output full and stalled, lanes 0..2 still accept bytes. The 4th byte stalls (in_ready=0) until out_ready.
- out_be is always contiguous from lane 0 (e.g. 0001, 0011, 0111, 1111).

Test Plan:
- Bytes 11,22,33,44 back-to-back, out_ready=1 → one cycle after 4th accept:
  - out_word=32'h44332211, out_be=4'b1111, out_count=4
  - out_valid high exactly 1 cycle.
- out_ready=0, 8 bytes 01..08 offered continuously →
  - word 32'h04030201 held stable
  - bytes 05..07 accepted; in_ready=0 while 08 is offered
  - raise out_ready → 08 accepted same cycle, next word 32'h08070605 with out_valid continuous.
- Bytes AA,BB then flush pulse (FLUSH_FILL=00) → out_word=32'h0000BBAA, out_be=4'b0011, out_count=2, lane returns to 0.
- Bytes AA,BB, then CC with flush in the same cycle → out_word=32'h00CCBBAA, out_be=4'b0111, out_count=3.
- Flush with empty packer → out_valid stays 0. Flush while the output is stalled with 1 byte buffered → deferred, emitted the cycle after out_ready.
- Bytes 5A,5B then rst for 1 cycle, then 01,02,03,04 →
  - out_valid=0 during reset
  - result 32'h04030201 with be 4'b1111 (no stale lanes).
